// File: rtl/axil_led_sequencer.sv
// AXI-Lite read-only master that walks an LED pattern table in BRAM.
// Each 32-bit entry: [31:24] hold ticks (0 means 1), [23] last, [LED_WIDTH-1:0] pattern.
module axil_led_sequencer #(
    parameter int unsigned            DATA_WIDTH  = 32,
    parameter int unsigned            ADDR_WIDTH  = 16,
    parameter int unsigned            LED_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
    parameter int unsigned            NUM_ENTRIES = 16,
    parameter int unsigned            TICK_DIV    = 25000000
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic                  enable,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready,
    output logic [LED_WIDTH-1:0]  LED,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [PRE_W-1:0] PRE_TC   = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StAr, StR, StHold} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     next_idx_q, next_idx_d;
    logic [7:0]           hold_cnt_q, hold_cnt_d;
    logic [PRE_W-1:0]     presc_q, presc_d;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic                 err_q, err_d;

    logic [7:0]       entry_hold;
    logic             entry_last;
    logic [IDX_W-1:0] idx_wrap;
    logic             hold_done;
    logic             unused_rdata;

    assign entry_hold   = m_axil_rdata[31:24];
    assign entry_last   = m_axil_rdata[23];
    assign idx_wrap     = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    // Last prescaler tick of the last hold tick: leave HOLD on this edge.
    assign hold_done    = (presc_q == PRE_TC) && (hold_cnt_q == 8'd1);
    assign unused_rdata = ^m_axil_rdata;

    // State register.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (enable) state_d = StAr;
            StAr:   if (m_axil_arready) state_d = StR;
            StR:    if (m_axil_rvalid) state_d = StHold;
            StHold: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (hold_done) begin
                    state_d = StAr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        m_axil_arvalid = 1'b0;
        m_axil_rready  = 1'b0;
        busy           = 1'b1;
        unique case (state_q)
            StIdle:  busy = 1'b0;
            StAr:    m_axil_arvalid = 1'b1;
            StR:     m_axil_rready = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: entry capture, hold timing and index stepping.
    always_comb begin
        idx_d      = idx_q;
        next_idx_d = next_idx_q;
        hold_cnt_d = hold_cnt_q;
        presc_d    = presc_q;
        led_d      = led_q;
        err_d      = err_q;
        unique case (state_q)
            StIdle: begin
                idx_d   = '0;
                presc_d = '0;
            end
            StR: begin
                if (m_axil_rvalid) begin
                    presc_d = '0;
                    if (m_axil_rresp == 2'b00) begin
                        led_d      = m_axil_rdata[LED_WIDTH-1:0];
                        hold_cnt_d = (entry_hold == 8'd0) ? 8'd1 : entry_hold;
                        next_idx_d = entry_last ? '0 : idx_wrap;
                    end else begin
                        // Bad entry: flag it, keep the display, move on after one tick.
                        err_d      = 1'b1;
                        hold_cnt_d = 8'd1;
                        next_idx_d = idx_wrap;
                    end
                end
            end
            StHold: begin
                if (!enable) begin
                    idx_d   = '0;
                    presc_d = '0;
                end else if (presc_q == PRE_TC) begin
                    presc_d    = '0;
                    hold_cnt_d = hold_cnt_q - 8'd1;
                    if (hold_cnt_q == 8'd1) idx_d = next_idx_q;
                end else begin
                    presc_d = presc_q + PRE_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            idx_q      <= '0;
            next_idx_q <= '0;
            hold_cnt_q <= 8'd1;
            presc_q    <= '0;
            led_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            next_idx_q <= next_idx_d;
            hold_cnt_q <= hold_cnt_d;
            presc_q    <= presc_d;
            led_q      <= led_d;
            err_q      <= err_d;
        end
    end

    assign m_axil_araddr = BASE_ADDR + ADDR_WIDTH'({idx_q, 2'b00});
    assign m_axil_arprot = 3'b000;
    assign LED           = led_q;
    assign err           = err_q;

endmodule

// File: doc/axil_led_sequencer.md
Name: axil_led_sequencer

Overview:
- AXI-Lite read-only master that walks a pattern table held in the application BRAM and drives the board LEDs from it.
- Each table entry carries an LED pattern, a hold time and a last-entry flag. The block fetches one entry, displays it for the programmed time, then fetches the next.
- Sits beside the host AXI-Lite port in the tandem application. The top-level interconnect shares the BRAM between the host (which writes the table) and this block (which reads it).

Parameters:
- DATA_WIDTH, 32, AXI-Lite data width; must be 32.
- ADDR_WIDTH, 16, AXI-Lite address width.
- LED_WIDTH, 8, LED output width; must be <= 23.
- BASE_ADDR, 16'h0000, byte address of table entry 0.
- NUM_ENTRIES, 16, maximum table length; index wraps after entry NUM_ENTRIES-1.
- TICK_DIV, 25000000, axi_aclk cycles per hold tick; must be >= 1.

Ports:
- axi_aclk  in  1  clock; one clock domain for the whole block.
- axi_aresetn  in  1  reset; asynchronous assert, active-low.
- enable  in  1  run the sequence while high.
- m_axil_araddr  out  ADDR_WIDTH  read address.
- m_axil_arprot  out  3  constant 3'b000.
- m_axil_arvalid  out  1  read address valid.
- m_axil_arready  in  1  read address ready.
- m_axil_rdata  in  DATA_WIDTH  read data.
- m_axil_rresp  in  2  read response.
- m_axil_rvalid  in  1  read data valid.
- m_axil_rready  out  1  read data ready.
- LED  out  LED_WIDTH  displayed pattern.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky flag; set on any rresp other than OKAY.

Behaviour:
- Reset: the only reset is axi_aresetn, asynchronous assert, active-low. While it is low: LED=0, arvalid=0, rready=0, busy=0, err=0, idx=0, state=IDLE. Reset mid-transaction aborts immediately; the block issues nothing further until reset is released.
- Entry format:
  - rdata[LED_WIDTH-1:0] = pattern.
  - rdata[23] = last; after this entry the index returns to 0.
  - rdata[31:24] = hold in ticks; a value of 0 is treated as 1.
- Address: araddr = BASE_ADDR + 4*idx, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH).
- FSM:
  - IDLE: if enable=1, go to AR next cycle; idx=0.
  - AR: arvalid=1, araddr held stable until arready. On arvalid&arready, go to R.
  - R: rready=1. On rvalid&rready:
    - rresp==OKAY: LED<=pattern, hold_cnt<=max(hold,1), next_idx = (last || idx==NUM_ENTRIES-1) ? 0 : idx+1.
    - rresp!=OKAY: err<=1, LED unchanged, hold_cnt<=1, next_idx = wrap(idx+1).
    - Either case: go to HOLD.
  - HOLD: a prescaler counts 0..TICK_DIV-1. On terminal count, hold_cnt decrements. When hold_cnt reaches 0: idx<=next_idx, prescaler cleared; go to AR if enable=1, else IDLE.
- Latency:
  - enable sampled high in IDLE: arvalid rises on the following cycle.
  - LED updates on the cycle after the r handshake.
  - Time from LED update to the next arvalid = hold*TICK_DIV cycles.
- Handshake rules:
  - Never drop arvalid or change araddr before arready.
  - Only one outstanding read at a time.
  - rready is low outside R.
  - arvalid and rready are never high in the same cycle.
- enable deasserted in AR or R: the current transaction completes and the LED is updated. HOLD is then cut short: the block goes to IDLE on the next cycle and resets idx to 0. enable deasserted in HOLD: go to IDLE next cycle.
- LED keeps its last value in IDLE.
- err clears only on reset.
- Simultaneous arvalid&arready in the first AR cycle is legal: the block spends one cycle in AR.

Test Plan:
- TICK_DIV=4. Table: 0x02000001, 0x01000002, 0x01800004 (last). enable=1 -> LED sequence 01 (8 cycles), 02 (4 cycles), 04 (4 cycles), then 01 again. Reads go to 0x0000, 0x0004, 0x0008, 0x0000.
- Slave holds arready low for 5 cycles -> arvalid stays high and araddr stays stable for all 5 cycles; exactly one AR handshake occurs.
- Entry 0 returns rresp=2'b10 -> err=1, LED stays 00, the next read goes to 0x0004 after 4 cycles, and err persists through the following OKAY reads.
- No last flag in any entry, NUM_ENTRIES=4 -> reads go to 0x0, 0x4, 0x8, 0xC, 0x0.
- enable drops while in R with rvalid delayed 3 cycles -> the read completes, LED updates, busy=0 within 2 cycles, and no further arvalid is issued. Re-enable -> the read address is 0x0000.
- axi_aresetn pulsed low mid-HOLD with LED=0x04 -> LED=0, busy=0 and arvalid=0 immediately (asynchronously); after release and enable=1, the first read is at 0x0000.
